// File: rtl/rat_return_stack.sv
// Return-address stack for the RAT CPU.
// Captures PC_COUNT (+1 for CALL, unmodified for interrupt entry) and
// presents the top entry combinationally so the PC can load it on the
// same edge that the entry is popped.
module rat_return_stack #(
    parameter int DEPTH = 16,
    parameter int AW    = 10
) (
    input  logic                         CLK,
    input  logic                         RST,
    input  logic [AW-1:0]                PC_COUNT,
    input  logic                         CALL_PUSH,
    input  logic                         INT_PUSH,
    input  logic                         POP,
    input  logic                         CLR_ERR,
    output logic [AW-1:0]                RET_ADDR,
    output logic                         EMPTY,
    output logic                         FULL,
    output logic                         OVF,
    output logic                         UNF,
    output logic [$clog2(DEPTH+1)-1:0]   LEVEL
);

    localparam int LW = $clog2(DEPTH + 1);
    localparam int IW = $clog2(DEPTH);
    localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);
    localparam logic [LW-1:0] ONE_L   = LW'(1);

    // Entry storage; deliberately not reset, only LEVEL defines validity.
    logic [AW-1:0] mem_q [DEPTH];

    logic [LW-1:0] level_q, level_d;
    logic          ovf_q, ovf_d;
    logic          unf_q, unf_d;

    logic          push;
    logic [AW-1:0] push_val;
    logic          empty;
    logic          full;
    logic [IW-1:0] top_idx;
    logic          wr_en;
    logic [IW-1:0] wr_idx;

    assign empty   = (level_q == '0);
    assign full    = (level_q == DEPTH_L);
    // Only meaningful when not empty; LEVEL-1 always fits the entry index.
    assign top_idx = IW'(level_q - ONE_L);

    // Interrupt entry wins over CALL: the interrupted instruction must re-run,
    // whereas CALL returns to the instruction after itself (wraps at 2^AW).
    assign push     = CALL_PUSH | INT_PUSH;
    assign push_val = INT_PUSH ? PC_COUNT : (PC_COUNT + AW'(1));

    // Next-state decode for level, sticky error flags and the entry write.
    always_comb begin
        level_d = level_q;
        ovf_d   = ovf_q & ~CLR_ERR;
        unf_d   = unf_q & ~CLR_ERR;
        wr_en   = 1'b0;
        wr_idx  = '0;
        if (push && POP) begin
            // Pop-then-push: the top is replaced, never an overflow.
            wr_en = 1'b1;
            if (empty) begin
                wr_idx  = '0;
                level_d = ONE_L;
                unf_d   = 1'b1;
            end else begin
                wr_idx  = top_idx;
            end
        end else if (push) begin
            if (full) begin
                ovf_d = 1'b1;
            end else begin
                wr_en   = 1'b1;
                wr_idx  = IW'(level_q);
                level_d = level_q + ONE_L;
            end
        end else if (POP) begin
            if (empty) begin
                unf_d = 1'b1;
            end else begin
                level_d = level_q - ONE_L;
            end
        end
    end

    // Level counter and sticky flags; cleared immediately on RST.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            level_q <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            level_q <= level_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    // Entry write port.
    always_ff @(posedge CLK) begin
        if (wr_en) begin
            mem_q[wr_idx] <= push_val;
        end
    end

    // Zero-latency top-of-stack read for the PC DIN mux.
    assign RET_ADDR = empty ? '0 : mem_q[top_idx];
    assign EMPTY    = empty;
    assign FULL     = full;
    assign OVF      = ovf_q;
    assign UNF      = unf_q;
    assign LEVEL    = level_q;

endmodule

// File: tb/tb_rat_return_stack.sv
// Directed bench for rat_return_stack: push/pop nesting, CALL wrap,
// overflow/underflow flags, simultaneous push+pop and asynchronous reset.
module tb_rat_return_stack;

    localparam int DEPTH = 16;
    localparam int AW    = 10;
    localparam int LW    = $clog2(DEPTH + 1);

    logic           CLK = 1'b0;
    logic           RST;
    logic [AW-1:0]  PC_COUNT;
    logic           CALL_PUSH, INT_PUSH, POP, CLR_ERR;
    logic [AW-1:0]  RET_ADDR;
    logic           EMPTY, FULL, OVF, UNF;
    logic [LW-1:0]  LEVEL;

    int checks = 0;
    int errors = 0;

    rat_return_stack #(.DEPTH(DEPTH), .AW(AW)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .PC_COUNT  (PC_COUNT),
        .CALL_PUSH (CALL_PUSH),
        .INT_PUSH  (INT_PUSH),
        .POP       (POP),
        .CLR_ERR   (CLR_ERR),
        .RET_ADDR  (RET_ADDR),
        .EMPTY     (EMPTY),
        .FULL      (FULL),
        .OVF       (OVF),
        .UNF       (UNF),
        .LEVEL     (LEVEL)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One clocked transaction; outputs are stable 1 time unit after the edge.
    task automatic cycle(input logic call, input logic intr, input logic pop,
                         input logic clr, input logic [AW-1:0] pc);
        CALL_PUSH = call;
        INT_PUSH  = intr;
        POP       = pop;
        CLR_ERR   = clr;
        PC_COUNT  = pc;
        @(posedge CLK);
        #1;
        CALL_PUSH = 1'b0;
        INT_PUSH  = 1'b0;
        POP       = 1'b0;
        CLR_ERR   = 1'b0;
        $display("txn call=%0d int=%0d pop=%0d clr=%0d pc=0x%03h -> level=%0d ret=0x%03h empty=%0d full=%0d ovf=%0d unf=%0d",
                 call, intr, pop, clr, pc, LEVEL, RET_ADDR, EMPTY, FULL, OVF, UNF);
    endtask

    initial begin
        RST = 1'b1;
        CALL_PUSH = 1'b0; INT_PUSH = 1'b0; POP = 1'b0; CLR_ERR = 1'b0;
        PC_COUNT = '0;
        #12;
        // 1: reset state, then first CALL
        chk("rst_empty", EMPTY, 1);
        chk("rst_full", FULL, 0);
        chk("rst_level", LEVEL, 0);
        chk("rst_ret", RET_ADDR, 0);
        chk("rst_ovf", OVF, 0);
        chk("rst_unf", UNF, 0);
        RST = 1'b0;
        cycle(1, 0, 0, 0, 10'h015);
        chk("t1_level", LEVEL, 1);
        chk("t1_ret", RET_ADDR, 10'h016);

        // 2: nesting CALL then interrupt, unwind
        cycle(1, 0, 0, 0, 10'h028);
        chk("t2_call_ret", RET_ADDR, 10'h029);
        cycle(0, 1, 0, 0, 10'h100);
        chk("t2_int_ret", RET_ADDR, 10'h100);
        chk("t2_int_level", LEVEL, 3);
        cycle(0, 0, 1, 0, 10'h000);
        chk("t2_pop1_ret", RET_ADDR, 10'h029);
        cycle(0, 0, 1, 0, 10'h000);
        chk("t2_pop2_ret", RET_ADDR, 10'h016);
        cycle(0, 0, 1, 0, 10'h000);
        chk("t2_pop3_empty", EMPTY, 1);
        chk("t2_pop3_ret", RET_ADDR, 0);

        // 3: CALL return address wraps
        cycle(1, 0, 0, 0, 10'h3FF);
        chk("t3_ret", RET_ADDR, 10'h000);
        chk("t3_level", LEVEL, 1);
        chk("t3_empty", EMPTY, 0);
        cycle(0, 0, 1, 0, 10'h000);
        chk("t3_pop_level", LEVEL, 0);

        // 4: fill, overflow, clear, replace-top while full, drain
        for (int i = 0; i < DEPTH; i++) cycle(1, 0, 0, 0, AW'(i));
        chk("t4_full", FULL, 1);
        chk("t4_full_ret", RET_ADDR, 10'h010);
        chk("t4_full_level", LEVEL, 16);
        cycle(1, 0, 0, 0, 10'h200);
        chk("t4_ovf_level", LEVEL, 16);
        chk("t4_ovf_ret", RET_ADDR, 10'h010);
        chk("t4_ovf", OVF, 1);
        chk("t4_ovf_unf", UNF, 0);
        cycle(0, 0, 0, 1, 10'h000);
        chk("t4_clr_ovf", OVF, 0);
        cycle(1, 0, 1, 0, 10'h300);
        chk("t4_swap_ret", RET_ADDR, 10'h301);
        chk("t4_swap_level", LEVEL, 16);
        chk("t4_swap_ovf", OVF, 0);
        cycle(0, 0, 1, 0, 10'h000);
        chk("t4_pop_ret", RET_ADDR, 10'h00F);
        chk("t4_pop_full", FULL, 0);
        for (int i = 0; i < DEPTH - 1; i++) cycle(0, 0, 1, 0, 10'h000);
        chk("t4_drain_empty", EMPTY, 1);
        chk("t4_drain_unf", UNF, 0);

        // 5: underflow, simultaneous push+pop, INT over CALL
        cycle(0, 0, 1, 0, 10'h000);
        chk("t5_unf", UNF, 1);
        chk("t5_unf_level", LEVEL, 0);
        cycle(1, 0, 0, 0, 10'h01F);
        chk("t5_push_ret", RET_ADDR, 10'h020);
        cycle(1, 0, 1, 0, 10'h050);
        chk("t5_swap_level", LEVEL, 1);
        chk("t5_swap_ret", RET_ADDR, 10'h051);
        chk("t5_unf_sticky", UNF, 1);
        cycle(1, 1, 0, 0, 10'h060);
        chk("t5_both_ret", RET_ADDR, 10'h060);
        chk("t5_both_level", LEVEL, 2);

        // 6: asynchronous reset between edges
        cycle(1, 0, 0, 0, 10'h070);
        chk("t6_pre_level", LEVEL, 3);
        #2 RST = 1'b1;
        #1;
        chk("t6_async_level", LEVEL, 0);
        chk("t6_async_empty", EMPTY, 1);
        chk("t6_async_ret", RET_ADDR, 0);
        chk("t6_async_unf", UNF, 0);
        #2 RST = 1'b0;
        cycle(1, 0, 0, 0, 10'h005);
        chk("t6_ret", RET_ADDR, 10'h006);
        chk("t6_level", LEVEL, 1);

        // Push+pop on empty sets UNF; set beats a same-cycle clear
        cycle(0, 0, 1, 0, 10'h000);
        cycle(0, 1, 1, 0, 10'h123);
        chk("t7_swap_empty_level", LEVEL, 1);
        chk("t7_swap_empty_ret", RET_ADDR, 10'h123);
        chk("t7_swap_empty_unf", UNF, 1);
        cycle(0, 0, 0, 1, 10'h000);
        chk("t7_clr_unf", UNF, 0);
        cycle(0, 0, 1, 0, 10'h000);
        cycle(0, 0, 1, 1, 10'h000);
        chk("t7_set_wins", UNF, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/rat_return_stack.md
Name: rat_return_stack

Overview:
- Hardware return-address stack for the RAT CPU; it is the reader/writer on the other side of the program counter interface.
- On CALL or interrupt entry it captures the current PC_COUNT. On RET/RETI it presents the saved address for the program counter's DIN, so the PC loads it with PC_LD.
- Sits between the program counter and the PC input mux; driven by the control unit FSM.

Parameters:
DEPTH, 16, number of return-address entries (power of two not required, ≥2)
AW, 10, address width; matches PC_COUNT/DIN width

Ports:
CLK  input  1  system clock, all state updates on rising edge
RST  input  1  asynchronous active-high reset
PC_COUNT  input  AW  current program counter value
CALL_PUSH  input  1  push PC_COUNT+1 (return address after CALL)
INT_PUSH  input  1  push PC_COUNT unmodified (interrupt entry; interrupted instruction not yet executed)
POP  input  1  pop top entry (RET/RETI)
CLR_ERR  input  1  clear sticky OVF/UNF flags
RET_ADDR  output  AW  top-of-stack address, to PC DIN mux
EMPTY  output  1  no valid entries
FULL  output  1  DEPTH valid entries
OVF  output  1  sticky: push attempted while full
UNF  output  1  sticky: pop attempted while empty
LEVEL  output  clog2(DEPTH+1)  current entry count

Behaviour:
- Reset (asynchronous, while RST=1): LEVEL=0, EMPTY=1, FULL=0, OVF=0, UNF=0, RET_ADDR=0. Entry storage is not reset.
- Push value selection:
  - CALL_PUSH: value = (PC_COUNT+1) mod 2^AW, so 0x3FF wraps to 0x000.
  - INT_PUSH: value = PC_COUNT.
  - Both asserted: INT_PUSH wins; one entry only.
- RET_ADDR is combinational from stored state: mem[LEVEL-1] when LEVEL>0, else 0. Zero latency.
  - The control unit asserts POP and PC_LD in the same cycle.
  - The PC loads RET_ADDR at the same edge the entry is removed.
- Push only, not full: mem[LEVEL] <= value, LEVEL+1.
- Push only, full: no write, LEVEL unchanged, OVF <= 1.
- Pop only, not empty: LEVEL-1. The entry is not cleared.
- Pop only, empty: no change to LEVEL, UNF <= 1.
- Push and pop in the same cycle (pop-then-push, top replaced):
  - LEVEL>0: mem[LEVEL-1] <= value, LEVEL unchanged. Applies when full too; no OVF.
  - LEVEL=0: mem[0] <= value, LEVEL becomes 1, UNF <= 1.
- Flag derivation:
  - EMPTY = (LEVEL==0) and FULL = (LEVEL==DEPTH), both combinational.
  - OVF/UNF are registered, sticky until CLR_ERR or RST.
  - CLR_ERR in the same cycle as a new error event: the set wins.
- No wrap-around of LEVEL under any input combination; it stays in 0..DEPTH.
- Reset asserted mid-operation clears immediately, without waiting for a clock. After RST deasserts, the first edge with a push writes mem[0].
- Inputs are sampled only on CLK rising edge; no internal FSM beyond the LEVEL counter and flag registers.

Test Plan:
1. After RST pulse: EMPTY=1, FULL=0, LEVEL=0, RET_ADDR=0x000, OVF=UNF=0. Then PC_COUNT=0x015, CALL_PUSH=1 one cycle -> LEVEL=1, RET_ADDR=0x016.
2. Nesting:
   - Stimulus: CALL_PUSH at PC_COUNT=0x028, then INT_PUSH at PC_COUNT=0x100 (on top of case 1).
   - Required: RET_ADDR=0x100, then POP -> 0x029, then POP -> 0x016, then POP -> EMPTY=1, RET_ADDR=0.
3. Wrap: PC_COUNT=0x3FF, CALL_PUSH -> RET_ADDR=0x000, LEVEL=1.
4. Full/overflow:
   - 16 CALL_PUSHes with PC_COUNT=0..15 -> FULL=1, RET_ADDR=0x010.
   - 17th push with PC_COUNT=0x200 -> LEVEL=16, RET_ADDR still 0x010, OVF=1.
   - CLR_ERR -> OVF=0.
5. Underflow and simultaneous:
   - POP on empty -> UNF=1, LEVEL=0.
   - Then push 0x020 (CALL at 0x01F), then CALL_PUSH+POP at PC_COUNT=0x050 -> LEVEL=1, RET_ADDR=0x051.
   - INT_PUSH+CALL_PUSH at 0x060 -> RET_ADDR=0x060, LEVEL=2.
6. Async reset: with LEVEL=3, raise RST mid-cycle (between edges) -> LEVEL=0, EMPTY=1 before next edge. Release, then CALL_PUSH at 0x005 -> RET_ADDR=0x006, LEVEL=1.
